axis_frame_source: RTL and testbench



---
 rtl/axis_frame_source.sv | 197 +++++++++++++++++++
 tb/tb_axis_frame_source.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_source.sv
// AXI4-Stream synthetic video frame source: solid, ramp, colour-bar and checkerboard frames.
// TUSER marks the first pixel of a frame, TLAST the last pixel of each line.
module axis_frame_source #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic [3:0]  M_AXIS_TKEEP,
    output logic [3:0]  M_AXIS_TSTRB,
    output logic        M_AXIS_TUSER,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TID,
    output logic        M_AXIS_TDEST
);
    localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BAR_W = WIDTH / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    // The frame_done cycle always has TVALID low, so the gap is at least one cycle.
    localparam int unsigned GAP_N = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
    localparam int unsigned GW    = (GAP_N > 1) ? $clog2(GAP_N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

    state_t          r_state, w_state_nx;
    logic [XW-1:0]   r_x, w_x_nx;
    logic [YW-1:0]   r_y, w_y_nx;
    logic [2:0]      r_bar, w_bar_nx;
    logic [BW-1:0]   r_bcnt, w_bcnt_nx;
    logic [GW-1:0]   r_gap, w_gap_nx;
    logic [1:0]      r_pat, w_pat_nx;
    logic [23:0]     r_col, w_col_nx;
    logic            r_valid, w_valid_nx;
    logic            r_done, w_done_nx;
    logic [15:0]     r_count, w_count_nx;
    logic [23:0]     r_data, w_pix;
    logic            r_user, r_last, r_busy;
    logic            w_load, w_first, w_eol, w_eof, w_chk;

    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign frame_count   = r_count;
    assign M_AXIS_TVALID = r_valid;
    assign M_AXIS_TDATA  = {8'h00, r_data};
    assign M_AXIS_TKEEP  = 4'hF;
    assign M_AXIS_TSTRB  = 4'hF;
    assign M_AXIS_TUSER  = r_user;
    assign M_AXIS_TLAST  = r_last;
    assign M_AXIS_TID    = 1'b0;
    assign M_AXIS_TDEST  = 1'b0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // Next-state and next-beat coordinate logic.
    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_bar_nx   = r_bar;
        w_bcnt_nx  = r_bcnt;
        w_gap_nx   = r_gap;
        w_pat_nx   = r_pat;
        w_col_nx   = r_col;
        w_valid_nx = r_valid;
        w_done_nx  = 1'b0;
        w_count_nx = r_count;
        w_load     = 1'b0;
        w_first    = 1'b0;
        w_eol      = (r_x == XW'(WIDTH - 1));
        w_eof      = w_eol && (r_y == YW'(HEIGHT - 1));
        case (r_state)
            S_IDLE: begin
                if (start) w_first = 1'b1;
            end
            S_ACTIVE: begin
                if (M_AXIS_TREADY) begin
                    if (w_eof) begin
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b1;
                        w_count_nx = r_count + 16'd1;
                        w_gap_nx   = '0;
                        w_state_nx = continuous ? S_GAP : S_IDLE;
                    end else begin
                        w_load = 1'b1;
                        if (w_eol) begin
                            w_x_nx    = '0;
                            w_y_nx    = r_y + 1'b1;
                            w_bar_nx  = '0;
                            w_bcnt_nx = '0;
                        end else begin
                            w_x_nx = r_x + 1'b1;
                            if (r_bcnt == BW'(BAR_W - 1)) begin
                                w_bcnt_nx = '0;
                                w_bar_nx  = r_bar + 3'd1;
                            end else begin
                                w_bcnt_nx = r_bcnt + 1'b1;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_N - 1)) begin
                    if (continuous) w_first = 1'b1;
                    else            w_state_nx = S_IDLE;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_first) begin
            w_state_nx = S_ACTIVE;
            w_x_nx     = '0;
            w_y_nx     = '0;
            w_bar_nx   = '0;
            w_bcnt_nx  = '0;
            w_pat_nx   = pattern_sel;
            w_col_nx   = solid_color;
            w_valid_nx = 1'b1;
            w_load     = 1'b1;
        end
    end

    // Pixel value for the beat about to be presented.
    always_comb begin
        w_chk = 1'(w_x_nx >> 5) ^ 1'(w_y_nx >> 5);
        case (w_pat_nx)
            2'd0: w_pix = w_col_nx;
            2'd1: w_pix = {3{8'(w_x_nx)}};
            2'd2: begin
                case (w_bar_nx)
                    3'd0:    w_pix = 24'hFFFFFF;
                    3'd1:    w_pix = 24'hFFFF00;
                    3'd2:    w_pix = 24'h00FFFF;
                    3'd3:    w_pix = 24'h00FF00;
                    3'd4:    w_pix = 24'hFF00FF;
                    3'd5:    w_pix = 24'hFF0000;
                    3'd6:    w_pix = 24'h0000FF;
                    default: w_pix = 24'h000000;
                endcase
            end
            default: w_pix = w_chk ? 24'h000000 : 24'hFFFFFF;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_bar   <= '0;
            r_bcnt  <= '0;
            r_gap   <= '0;
            r_pat   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_data  <= '0;
            r_user  <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_bar   <= w_bar_nx;
            r_bcnt  <= w_bcnt_nx;
            r_gap   <= w_gap_nx;
            r_pat   <= w_pat_nx;
            r_col   <= w_col_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
            r_count <= w_count_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            if (w_load) begin
                r_data <= w_pix;
                r_user <= (w_x_nx == '0) && (w_y_nx == '0);
                r_last <= (w_x_nx == XW'(WIDTH - 1));
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: 16x4 frames with a 3-cycle gap,
// plus a 64x64 instance for the checkerboard pattern.
module tb_axis_frame_source;
    localparam int W   = 16;
    localparam int H   = 4;
    localparam int NB  = W * H;
    localparam int GAP = 3;
    localparam int BWD = 64;
    localparam int BHT = 64;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, continuous, busy, frame_done;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_color;
    logic [15:0] frame_count;
    logic        tvalid, tready, tuser, tlast, tid, tdest;
    logic [31:0] tdata;
    logic [3:0]  tkeep, tstrb;

    logic        b_start, b_busy, b_done, b_tvalid, b_tready, b_tuser, b_tlast, b_tid, b_tdest;
    logic [15:0] b_count;
    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep, b_tstrb;

    always #5 aclk = ~aclk;

    axis_frame_source #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .continuous(continuous),
        .pattern_sel(pattern_sel), .solid_color(solid_color), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
        .M_AXIS_TKEEP(tkeep), .M_AXIS_TSTRB(tstrb), .M_AXIS_TUSER(tuser),
        .M_AXIS_TLAST(tlast), .M_AXIS_TID(tid), .M_AXIS_TDEST(tdest)
    );

    axis_frame_source #(.WIDTH(BWD), .HEIGHT(BHT), .GAP_CYCLES(0)) u_big (
        .aclk(aclk), .aresetn(aresetn), .start(b_start), .continuous(1'b0),
        .pattern_sel(2'd3), .solid_color(24'h000000), .busy(b_busy),
        .frame_done(b_done), .frame_count(b_count),
        .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(b_tready), .M_AXIS_TDATA(b_tdata),
        .M_AXIS_TKEEP(b_tkeep), .M_AXIS_TSTRB(b_tstrb), .M_AXIS_TUSER(b_tuser),
        .M_AXIS_TLAST(b_tlast), .M_AXIS_TID(b_tid), .M_AXIS_TDEST(b_tdest)
    );

    typedef struct {
        logic [1:0]  pat;
        logic [23:0] col;
        int          x;
        int          y;
        logic [31:0] exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_count = 0;
    int          exp_gap = -1;
    int          exp_pat [8];
    logic [23:0] exp_col [8];
    logic [31:0] cap [NB];
    int          hk_pat_f, hk_pat_b, hk_cont_f, hk_cont_b, hk_start_f, hk_start_b;
    logic [1:0]  hk_pat_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel derived directly from the pattern definitions.
    function automatic logic [31:0] model_pix(input int pat, input logic [23:0] col,
                                              input int x, input int y, input int w);
        logic [23:0] c;
        logic [7:0]  r;
        r = 8'(x % 256);
        case (pat)
            0: c = col;
            1: c = {r, r, r};
            2: begin
                case (x / (w / 8))
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            default: c = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'h000000 : 24'hFFFFFF;
        endcase
        return {8'h00, c};
    endfunction

    task automatic clear_hooks();
        hk_pat_f = -1; hk_pat_b = -1; hk_pat_v = 2'd0;
        hk_cont_f = -1; hk_cont_b = -1;
        hk_start_f = -1; hk_start_b = -1;
        exp_gap = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        check("tvalid_after_start", tvalid, 1'b1);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_tvalid", tvalid, 1'b0);
            check("idle_busy", busy, 1'b0);
            @(posedge aclk); #1;
        end
    endtask

    // Consume nframes frames from the 16x4 instance, checking every beat and frame boundary.
    task automatic collect(input int nframes, input int rdy_pct);
        int frame, idx, cyc, gap, x, y;
        bit pend_done, hold, in_gap;
        logic [31:0] hd;
        logic hu, hl;
        frame = 0; idx = 0; cyc = 0; gap = 0;
        pend_done = 0; hold = 0; in_gap = 0;
        hd = '0; hu = 0; hl = 0;
        while ((frame < nframes || pend_done) && cyc < 4000) begin
            start  = 1'b0;
            tready = ($urandom_range(0, 99) < rdy_pct);
            check("frame_done", frame_done, pend_done);
            if (pend_done) begin
                exp_count++;
                check("frame_count", frame_count, 32'(exp_count[15:0]));
                check("tvalid_after_last", tvalid, 1'b0);
                pend_done = 0;
            end
            if (hold && tvalid) begin
                check("stall_tdata", tdata, hd);
                check("stall_tuser", tuser, hu);
                check("stall_tlast", tlast, hl);
            end
            if (idx > 0) check("tvalid_mid_frame", tvalid, 1'b1);
            if (in_gap) begin
                if (!tvalid) gap++;
                else begin
                    if (exp_gap >= 0) check("gap_cycles", gap, exp_gap);
                    in_gap = 0;
                end
            end
            if (tvalid && tready) begin
                x = idx % W;
                y = idx / W;
                check("tdata", tdata, model_pix(exp_pat[frame], exp_col[frame], x, y, W));
                check("tuser", tuser, idx == 0);
                check("tlast", tlast, x == W - 1);
                cap[idx] = tdata;
                if (frame == hk_pat_f && idx == hk_pat_b) pattern_sel = hk_pat_v;
                if (frame == hk_cont_f && idx == hk_cont_b) continuous = 1'b0;
                if (frame == hk_start_f && idx == hk_start_b) start = 1'b1;
                idx++;
                if (idx == NB) begin
                    idx = 0; frame++; pend_done = 1; in_gap = 1; gap = 0;
                end
                hold = 0;
            end else begin
                hold = tvalid;
                hd = tdata; hu = tuser; hl = tlast;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 4000) begin
            n_cmp++; n_err++;
            $display("FAIL collect_timeout: got %0d frames expected %0d", frame, nframes);
        end
        check("frame_done_width", frame_done, 1'b0);
    endtask

    vec_t vt [12];
    vec_t bt [4];
    logic [31:0] bcap [4];

    initial begin
        int beats, cyc, bx, by;
        logic [1:0] rp;
        logic [23:0] rc;

        vt[0]  = '{2'd0, 24'h123456, 0, 0, 32'h00123456};
        vt[1]  = '{2'd0, 24'h123456, 15, 3, 32'h00123456};
        vt[2]  = '{2'd2, 24'h000000, 1, 0, 32'h00FFFFFF};
        vt[3]  = '{2'd2, 24'h000000, 2, 0, 32'h00FFFF00};
        vt[4]  = '{2'd2, 24'h000000, 5, 1, 32'h0000FFFF};
        vt[5]  = '{2'd2, 24'h000000, 9, 2, 32'h00FF00FF};
        vt[6]  = '{2'd2, 24'h000000, 12, 0, 32'h000000FF};
        vt[7]  = '{2'd2, 24'h000000, 15, 3, 32'h00000000};
        vt[8]  = '{2'd1, 24'h000000, 7, 2, 32'h00070707};
        vt[9]  = '{2'd1, 24'h000000, 15, 0, 32'h000F0F0F};
        vt[10] = '{2'd3, 24'h000000, 3, 3, 32'h00FFFFFF};
        vt[11] = '{2'd0, 24'hA5C30F, 8, 1, 32'h00A5C30F};
        bt[0]  = '{2'd3, 24'h0, 31, 0, 32'h00FFFFFF};
        bt[1]  = '{2'd3, 24'h0, 32, 0, 32'h00000000};
        bt[2]  = '{2'd3, 24'h0, 0, 32, 32'h00000000};
        bt[3]  = '{2'd3, 24'h0, 32, 32, 32'h00FFFFFF};

        clear_hooks();
        aresetn = 1'b0; start = 1'b0; continuous = 1'b0; pattern_sel = 2'd0;
        solid_color = 24'h0; tready = 1'b0; b_start = 1'b0; b_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_count", frame_count, 32'h0);
        check("tkeep", tkeep, 4'hF);
        check("tstrb", tstrb, 4'hF);
        check("tid_tdest", {tid, tdest}, 2'b00);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Reset asserted while beat 20 is on the bus abandons the frame.
        pattern_sel = 2'd0; solid_color = 24'hABCDEF; tready = 1'b1;
        pulse_start();
        repeat (20) @(posedge aclk);
        #1;
        check("beat20_tdata", tdata, 32'h00ABCDEF);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_tvalid", tvalid, 1'b0);
        check("async_rst_tdata", tdata, 32'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_count", frame_count, 32'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        idle_check(2);

        // Basic solid frame after reset.
        pattern_sel = 2'd0; solid_color = 24'h123456;
        exp_pat[0] = 0; exp_col[0] = 24'h123456;
        pulse_start();
        collect(1, 100);
        idle_check(3);

        // Table-driven pixel spot checks, one frame per row.
        for (int i = 0; i < 12; i++) begin
            pattern_sel = vt[i].pat; solid_color = vt[i].col;
            exp_pat[0] = int'(vt[i].pat); exp_col[0] = vt[i].col;
            pulse_start();
            collect(1, 100);
            check($sformatf("vec%0d_pixel", i), cap[vt[i].y * W + vt[i].x], vt[i].exp);
        end

        // Ramp under 50% backpressure; a start pulse mid-frame must be ignored.
        pattern_sel = 2'd1; exp_pat[0] = 1; exp_col[0] = 24'h0;
        hk_start_f = 0; hk_start_b = 30;
        pulse_start();
        collect(1, 50);
        idle_check(6);
        clear_hooks();

        // Continuous mode with gap, mid-frame pattern change, stop request and
        // a start pulse coinciding with the final transfer.
        continuous = 1'b1; pattern_sel = 2'd1; solid_color = 24'h0;
        exp_pat[0] = 1; exp_pat[1] = 2; exp_pat[2] = 2;
        exp_col[0] = 24'h0; exp_col[1] = 24'h0; exp_col[2] = 24'h0;
        hk_pat_f = 0; hk_pat_b = 10; hk_pat_v = 2'd2;
        hk_cont_f = 2; hk_cont_b = 5;
        hk_start_f = 2; hk_start_b = NB - 1;
        exp_gap = GAP;
        pulse_start();
        collect(3, 80);
        idle_check(8);
        clear_hooks();

        // Randomized single frames.
        for (int i = 0; i < 4; i++) begin
            rp = 2'($urandom_range(0, 3));
            rc = 24'($urandom);
            pattern_sel = rp; solid_color = rc;
            exp_pat[0] = int'(rp); exp_col[0] = rc;
            pulse_start();
            collect(1, $urandom_range(30, 100));
            idle_check(1);
        end

        // Checkerboard on the 64x64 instance.
        b_start = 1'b1;
        @(posedge aclk); #1;
        b_start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < BWD * BHT && cyc < 6000) begin
            if (b_tvalid) begin
                bx = beats % BWD;
                by = beats / BWD;
                check("big_tdata", b_tdata, model_pix(3, 24'h0, bx, by, BWD));
                check("big_tlast", b_tlast, bx == BWD - 1);
                for (int k = 0; k < 4; k++)
                    if (bt[k].x == bx && bt[k].y == by) bcap[k] = b_tdata;
                beats++;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        if (cyc >= 6000) begin
            n_cmp++; n_err++;
            $display("FAIL big_timeout: got %0d beats expected %0d", beats, BWD * BHT);
        end
        check("big_frame_done", b_done, 1'b1);
        check("big_frame_count", b_count, 32'd1);
        for (int k = 0; k < 4; k++)
            check($sformatf("checker_%0d_%0d", bt[k].x, bt[k].y), bcap[k], bt[k].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
